// File: rtl/bcd_count_ctrl_pkg.sv
// rtl/bcd_count_ctrl_pkg.sv - shared FSM state encodings and BCD digit constant
package bcd_count_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_count_ctrl_if.sv
// rtl/bcd_count_ctrl_if.sv - command/strobe inputs and digit/status outputs of the BCD count controller
interface bcd_count_ctrl_if #(
  parameter int NDIGITS = 4
);
  logic                 start;
  logic                 stop;
  logic                 clear;
  logic                 tick;
  logic [4*NDIGITS-1:0] digits;
  logic                 running;
  logic                 overflow;
  logic                 done;

  modport master (
    output start, stop, clear, tick,
    input  digits, running, overflow, done
  );

  modport slave (
    input  start, stop, clear, tick,
    output digits, running, overflow, done
  );
endinterface

// File: rtl/bcd_count_ctrl_decade.sv
// rtl/bcd_count_ctrl_decade.sv - one BCD decade (0..9), falling-edge, sync clear over enable-gated increment
module bcd_decade
  import bcd_count_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       is_nine
);

  logic [3:0] r_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= 4'd0;
    end else if (clr) begin
      r_q <= 4'd0;
    end else if (en) begin
      r_q <= (r_q == BCD_MAX) ? 4'd0 : r_q + 4'd1;
    end
  end

  assign q       = r_q;
  assign is_nine = (r_q == BCD_MAX);

endmodule

// File: rtl/bcd_count_ctrl.sv
// rtl/bcd_count_ctrl.sv - start/stop/clear sequencer for a cascaded BCD counter
// Optional terminal stop at all-9s: BCD_CTRL_TERMINAL_STOP_EN
module bcd_count_ctrl
  import bcd_count_ctrl_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_count_ctrl_if.slave        bus
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_running;
  logic                 r_overflow;
  logic                 w_tick_en;
  logic                 w_wrap;
  logic                 w_all_nine;
  logic [NDIGITS-1:0]   w_is_nine;
  logic [NDIGITS-1:0]   w_en;
  logic [4*NDIGITS-1:0] w_digits;

  assign w_all_nine = &w_is_nine;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (bus.stop) begin
            w_state_nxt = ST_HOLD;
          end
`ifdef BCD_CTRL_TERMINAL_STOP_EN
          else if (bus.tick && w_all_nine) begin
            w_state_nxt = ST_DONE;
          end
`endif
        end
        // stop outranks start, so both together keep HOLD
        ST_HOLD: if (!bus.stop && bus.start) w_state_nxt = ST_RUN;
        ST_DONE: w_state_nxt = r_state;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_tick_en = (r_state == ST_RUN) && bus.tick && !bus.clear && !bus.stop;
    w_wrap    = 1'b0;
`ifdef BCD_CTRL_TERMINAL_STOP_EN
    w_tick_en = w_tick_en && !w_all_nine;
`else
    w_wrap    = w_tick_en && w_all_nine;
`endif
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_running  <= (w_state_nxt == ST_RUN);
      r_overflow <= w_wrap;
    end
  end

`ifdef BCD_CTRL_TERMINAL_STOP_EN
  logic r_done;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.done = r_done;
`else
  assign bus.done = 1'b0;
`endif

  // Decade k steps only when every lower decade is about to roll over
  for (genvar k = 0; k < NDIGITS; k++) begin : g_decade
    if (k == 0) begin : g_lsd
      assign w_en[k] = w_tick_en;
    end else begin : g_upper
      assign w_en[k] = w_tick_en & (&w_is_nine[k-1:0]);
    end

    bcd_decade u_decade (
      .clk     (clk),
      .rst     (rst),
      .en      (w_en[k]),
      .clr     (bus.clear),
      .q       (w_digits[4*k +: 4]),
      .is_nine (w_is_nine[k])
    );
  end

  assign bus.digits   = w_digits;
  assign bus.running  = r_running;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb/tb_bcd_count_ctrl.sv - directed self-checking bench for bcd_count_ctrl
module tb_bcd_count_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  bit   r_bad;

  bcd_count_ctrl_if #(.NDIGITS(4)) bus ();

  bcd_count_ctrl #(.NDIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input logic s, input logic p, input logic c, input logic t);
    bus.start = s;
    bus.stop  = p;
    bus.clear = c;
    bus.tick  = t;
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (bus.digits[4*i +: 4] > 4'd9) r_bad = 1'b1;
    end
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.tick = 1'b0;
    #3;
    n_cmp++; if (bus.digits !== 16'h0000) begin n_err++; $display("FAIL reset_digits: got %h expected 0000", bus.digits); end
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b expected 0", bus.running); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    #5;
    rst = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_start_count;
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (bus.digits !== 16'h0000 || bus.running !== 1'b0) begin n_err++; $display("FAIL idle_ignore: got %h/%b expected 0000/0", bus.digits, bus.running); end
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.digits !== 16'h0000 || bus.running !== 1'b1) begin n_err++; $display("FAIL start_edge: got %h/%b expected 0000/1", bus.digits, bus.running); end
    run_ticks(12);
    n_cmp++; if (bus.digits !== 16'h0012) begin n_err++; $display("FAIL count12: got %h expected 0012", bus.digits); end
    n_cmp++; if (bus.running !== 1'b1) begin n_err++; $display("FAIL count12_running: got %b expected 1", bus.running); end
  endtask

  task automatic test_pause;
    run_ticks(25);
    n_cmp++; if (bus.digits !== 16'h0037) begin n_err++; $display("FAIL pre_pause: got %h expected 0037", bus.digits); end
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (bus.running !== 1'b0) begin n_err++; $display("FAIL stop_running: got %b expected 0", bus.running); end
    run_ticks(4);
    n_cmp++; if (bus.digits !== 16'h0037) begin n_err++; $display("FAIL hold_digits: got %h expected 0037", bus.digits); end
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.digits !== 16'h0037 || bus.running !== 1'b1) begin n_err++; $display("FAIL resume_edge: got %h/%b expected 0037/1", bus.digits, bus.running); end
    run_ticks(3);
    n_cmp++; if (bus.digits !== 16'h0040) begin n_err++; $display("FAIL resume3: got %h expected 0040", bus.digits); end
  endtask

  task automatic test_cascade;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (bus.digits !== 16'h0000 || bus.running !== 1'b0) begin n_err++; $display("FAIL clear: got %h/%b expected 0000/0", bus.digits, bus.running); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    r_bad = 1'b0;
    run_ticks(999);
    n_cmp++; if (bus.digits !== 16'h0999) begin n_err++; $display("FAIL to999: got %h expected 0999", bus.digits); end
    run_ticks(1);
    n_cmp++; if (bus.digits !== 16'h1000) begin n_err++; $display("FAIL carry1000: got %h expected 1000", bus.digits); end
    n_cmp++; if (r_bad !== 1'b0) begin n_err++; $display("FAIL bcd_codes: got bad=%b expected 0", r_bad); end
  endtask

  task automatic test_wrap;
    run_ticks(8999);
    n_cmp++; if (bus.digits !== 16'h9999 || bus.overflow !== 1'b0) begin n_err++; $display("FAIL to9999: got %h/%b expected 9999/0", bus.digits, bus.overflow); end
    run_ticks(1);
`ifdef BCD_CTRL_TERMINAL_STOP_EN
    n_cmp++; if (bus.digits !== 16'h9999) begin n_err++; $display("FAIL term_digits: got %h expected 9999", bus.digits); end
    n_cmp++; if (bus.done !== 1'b1 || bus.running !== 1'b0 || bus.overflow !== 1'b0) begin n_err++; $display("FAIL term_status: got done=%b run=%b ovf=%b expected 1/0/0", bus.done, bus.running, bus.overflow); end
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    run_ticks(2);
    n_cmp++; if (bus.digits !== 16'h9999 || bus.done !== 1'b1 || bus.running !== 1'b0) begin n_err++; $display("FAIL term_sticky: got %h/%b/%b expected 9999/1/0", bus.digits, bus.done, bus.running); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (bus.digits !== 16'h0000 || bus.done !== 1'b0) begin n_err++; $display("FAIL term_clear: got %h/%b expected 0000/0", bus.digits, bus.done); end
`else
    n_cmp++; if (bus.digits !== 16'h0000) begin n_err++; $display("FAIL wrap_digits: got %h expected 0000", bus.digits); end
    n_cmp++; if (bus.overflow !== 1'b1 || bus.running !== 1'b1) begin n_err++; $display("FAIL wrap_pulse: got ovf=%b run=%b expected 1/1", bus.overflow, bus.running); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.overflow !== 1'b0 || bus.running !== 1'b1 || bus.digits !== 16'h0000) begin n_err++; $display("FAIL wrap_after: got ovf=%b run=%b %h expected 0/1/0000", bus.overflow, bus.running, bus.digits); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL wrap_done: got %b expected 0", bus.done); end
    run_ticks(1);
    n_cmp++; if (bus.digits !== 16'h0001) begin n_err++; $display("FAIL wrap_continue: got %h expected 0001", bus.digits); end
`endif
  endtask

  task automatic test_priority;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(5);
    n_cmp++; if (bus.digits !== 16'h0005) begin n_err++; $display("FAIL prio_pre: got %h expected 0005", bus.digits); end
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (bus.digits !== 16'h0000 || bus.running !== 1'b0) begin n_err++; $display("FAIL prio_clear: got %h/%b expected 0000/0", bus.digits, bus.running); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.digits !== 16'h0000 || bus.running !== 1'b0) begin n_err++; $display("FAIL prio_idle: got %h/%b expected 0000/0", bus.digits, bus.running); end
  endtask

  task automatic test_async_reset;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(3);
    n_cmp++; if (bus.digits !== 16'h0003) begin n_err++; $display("FAIL async_pre: got %h expected 0003", bus.digits); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.digits !== 16'h0000 || bus.running !== 1'b0 || bus.overflow !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL async_rst: got %h/%b/%b/%b expected 0000/0/0/0", bus.digits, bus.running, bus.overflow, bus.done); end
    #2;
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.digits !== 16'h0000 || bus.running !== 1'b0) begin n_err++; $display("FAIL async_idle: got %h/%b expected 0000/0", bus.digits, bus.running); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    r_bad = 1'b0;
    test_reset();
    test_start_count();
    test_pause();
    test_cascade();
    test_wrap();
    test_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
